// File: rtl/latch_seq_pkg.sv
// Shared types and elaboration-time helpers for the latch bank write sequencer.
//
// Contents:
//   state_e     - sequencer FSM states (IDLE, SETUP, OPEN, HOLD)
//   DEF_*       - default data width, slot count and timing windows
//   cnt_width   - width of the window down-counter for a given timing set
//   slot_width  - bits needed to address NSLOT latch slots
package latch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int DEF_DW        = 4;
    localparam int DEF_NSLOT     = 4;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_OPEN_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // The counter must hold the longest window length itself.
    function automatic int cnt_width(input int s, input int o, input int h);
        return $clog2(max3(s, o, h) + 1);
    endfunction

    function automatic int slot_width(input int nslot);
        return $clog2(nslot);
    endfunction

endpackage

// File: rtl/latch_bank_sequencer_rr_arbiter2.sv
// Two-input round-robin arbiter.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   req_i[1:0]  - request vector
//   update_i    - high on the edge a grant is accepted; advances the pointer
//   grant_o     - index of the winning requester (combinational)
//   valid_o     - at least one requester is asking
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       grant_o,
    output logic       valid_o
);

    // prio_q names the requester that wins a tie; 0 after reset.
    logic prio_q;
    logic prio_d;

    // NOTE: every signal written in a combinational block gets a default
    // assignment first, so no path through the block can infer a latch.
    always_comb begin
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = prio_q;
            default: grant_o = 1'b0;
        endcase
    end

    assign valid_o = |req_i;

    // After a grant the other requester is favoured on the next tie.
    assign prio_d = update_i ? ~grant_o : prio_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/latch_bank_sequencer.sv
// Write sequencer for a bank of NSLOT gated D latches shared by two requesters.
// Each granted write drives latch_d and one one-hot gate with fixed setup,
// open and hold windows counted in clk cycles.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req[1:0]                - level requests, held until ack
//   req_data0/1 [DW-1:0]    - write data per requester
//   req_slot0/1 [SW-1:0]    - target slot per requester
//   ack[1:0]                - one-cycle completion pulse per requester
//   grant_id                - owner of the current transaction
//   busy                    - sequencer not idle
//   latch_d [DW-1:0]        - data to the latch array
//   latch_g [NSLOT-1:0]     - one-hot gate enables, low outside OPEN
module latch_bank_sequencer
    import latch_seq_pkg::*;
#(
    parameter  int DW        = DEF_DW,
    parameter  int NSLOT     = DEF_NSLOT,
    parameter  int SETUP_CYC = DEF_SETUP_CYC,
    parameter  int OPEN_CYC  = DEF_OPEN_CYC,
    parameter  int HOLD_CYC  = DEF_HOLD_CYC,
    localparam int SW        = slot_width(NSLOT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [DW-1:0]    req_data0,
    input  logic [DW-1:0]    req_data1,
    input  logic [SW-1:0]    req_slot0,
    input  logic [SW-1:0]    req_slot1,
    output logic [1:0]       ack,
    output logic             grant_id,
    output logic             busy,
    output logic [DW-1:0]    latch_d,
    output logic [NSLOT-1:0] latch_g
);

    localparam int            CW       = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
    localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     data_q;
    logic [SW-1:0]     slot_q;
    logic              gid_q;
    logic [NSLOT-1:0]  latch_g_q, latch_g_d;
    logic [1:0]        ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              gnt;
    logic              gnt_valid;
    logic              capture;

    assign capture = (state_q == IDLE) && gnt_valid;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .update_i (capture),
        .grant_o  (gnt),
        .valid_o  (gnt_valid)
    );

    // State register, window counter, capture registers and output flops.
    // NOTE: everything that is visible at the latch array is cleared by the
    // asynchronous reset, so an aborted write drops its gate without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            slot_q    <= '0;
            gid_q     <= 1'b0;
            latch_g_q <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latch_g_q <= latch_g_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            // Frozen from capture until the next capture.
            if (capture) begin
                data_q <= gnt ? req_data1 : req_data0;
                slot_q <= gnt ? req_slot1 : req_slot0;
                gid_q  <= gnt;
            end
        end
    end

    // Next state: each window counts down to 1, then hands over.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_q == ONE) begin
                    state_d = OPEN;
                    cnt_d   = OPEN_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            OPEN: begin
                if (cnt_q == ONE) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            HOLD: begin
                if (cnt_q == ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // comes straight from a flop and is valid in the cycle the state is.
    always_comb begin
        latch_g_d = '0;
        ack_d     = '0;
        busy_d    = (state_d != IDLE);
        if (state_d == OPEN) begin
            latch_g_d[slot_q] = 1'b1;
        end
        if ((state_d == HOLD) && (cnt_d == ONE)) begin
            ack_d[gid_q] = 1'b1;
        end
    end

    assign latch_d  = data_q;
    assign latch_g  = latch_g_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Self-checking bench for latch_bank_sequencer. Two instances run side by
// side: dut0 with default timing (4 slots, 1/2/1) and dut1 with 8 slots and
// 3/1/2 timing. A transaction-level model records each expected capture in a
// per-instance queue; a negedge monitor derives the expected busy, gate, ack,
// data and grant values for every cycle from the queue head.
module tb_latch_bank_sequencer;

    typedef struct {
        int grant;
        int data;
        int slot;
        int cap;
    } txn_t;

    int ps  [2] = '{1, 3};
    int po  [2] = '{2, 1};
    int ph  [2] = '{1, 2};
    int pns [2] = '{4, 8};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req   [2];
    logic [3:0] rdata [2][2];
    logic [2:0] rslot [2][2];

    logic [1:0] ack0, ack1;
    logic       gid0, gid1, busy0, busy1;
    logic [3:0] ld0, ld1;
    logic [3:0] lg0;
    logic [7:0] lg1;

    logic [1:0] ack_a  [2];
    logic       gid_a  [2];
    logic       busy_a [2];
    logic [3:0] ld_a   [2];
    logic [7:0] lg_a   [2];

    always_comb begin
        ack_a[0]  = ack0;           ack_a[1]  = ack1;
        gid_a[0]  = gid0;           gid_a[1]  = gid1;
        busy_a[0] = busy0;          busy_a[1] = busy1;
        ld_a[0]   = ld0;            ld_a[1]   = ld1;
        lg_a[0]   = {4'b0000, lg0}; lg_a[1]   = lg1;
    end

    latch_bank_sequencer #(
        .DW(4), .NSLOT(4), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req[0]),
        .req_data0 (rdata[0][0]),
        .req_data1 (rdata[0][1]),
        .req_slot0 (rslot[0][0][1:0]),
        .req_slot1 (rslot[0][1][1:0]),
        .ack       (ack0),
        .grant_id  (gid0),
        .busy      (busy0),
        .latch_d   (ld0),
        .latch_g   (lg0)
    );

    latch_bank_sequencer #(
        .DW(4), .NSLOT(8), .SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req[1]),
        .req_data0 (rdata[1][0]),
        .req_data1 (rdata[1][1]),
        .req_slot0 (rslot[1][0]),
        .req_slot1 (rslot[1][1]),
        .ack       (ack1),
        .grant_id  (gid1),
        .busy      (busy1),
        .latch_d   (ld1),
        .latch_g   (lg1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic int tt(input int d);
        return ps[d] + po[d] + ph[d];
    endfunction

    // ---------------- reference model ----------------
    txn_t q0[$];
    txn_t q1[$];
    int   fav    [2];
    int   last_d [2];
    int   last_g [2];
    int   free_e [2];
    int   m_cap  [2];
    int   m_grant[2];
    bit   active [2];

    function automatic bit head(input int d, output txn_t t);
        t = '{grant: 0, data: 0, slot: 0, cap: 0};
        if (d == 0) begin
            if (q0.size() == 0) return 1'b0;
            t = q0[0];
        end else begin
            if (q1.size() == 0) return 1'b0;
            t = q1[0];
        end
        return 1'b1;
    endfunction

    // Capture happens at the first edge with a request once the previous
    // transaction's busy window plus one idle cycle has passed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                if (d == 0) q0.delete(); else q1.delete();
                fav[d]    = 0;
                last_d[d] = 0;
                last_g[d] = 0;
                free_e[d] = 0;
                active[d] = 1'b0;
            end else begin
                if (active[d] && cyc >= m_cap[d] + tt(d)) active[d] = 1'b0;
                if (!active[d] && cyc >= free_e[d] && req[d] != 2'b00) begin
                    int   w;
                    txn_t t;
                    if (req[d] == 2'b01)      w = 0;
                    else if (req[d] == 2'b10) w = 1;
                    else                      w = fav[d];
                    fav[d]     = 1 - w;
                    t.grant    = w;
                    t.data     = int'(rdata[d][w]);
                    t.slot     = int'(rslot[d][w]);
                    t.cap      = cyc;
                    if (d == 0) q0.push_back(t); else q1.push_back(t);
                    active[d]  = 1'b1;
                    m_cap[d]   = cyc;
                    m_grant[d] = w;
                    last_d[d]  = t.data;
                    last_g[d]  = w;
                    free_e[d]  = cyc + tt(d) + 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                txn_t       h;
                bit         hv;
                logic [7:0] eg;
                logic [1:0] ea;
                logic       eb;
                hv = head(d, h);
                eg = '0;
                ea = '0;
                eb = 1'b0;
                if (hv) begin
                    if (cyc >= h.cap && cyc <= h.cap + tt(d) - 1) eb = 1'b1;
                    if (cyc >= h.cap + ps[d] && cyc <= h.cap + ps[d] + po[d] - 1)
                        eg = 8'b0000_0001 << h.slot;
                    if (cyc == h.cap + tt(d) - 1) ea = 2'b01 << h.grant;
                end
                check("busy",     d, 32'(busy_a[d]), 32'(eb));
                check("latch_g",  d, 32'(lg_a[d]),   32'(eg));
                check("ack",      d, 32'(ack_a[d]),  32'(ea));
                check("latch_d",  d, 32'(ld_a[d]),   last_d[d]);
                check("grant_id", d, 32'(gid_a[d]),  last_g[d]);
                if (hv && cyc >= h.cap + tt(d) - 1) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int dst [2][2];   // 0: idle, 1: waiting for capture, 2: in flight

    task automatic clear_req();
        for (int d = 0; d < 2; d++) req[d] = 2'b00;
    endtask

    task automatic set_both(input int r, input logic [3:0] data,
                            input logic [2:0] s0, input logic [2:0] s1);
        rdata[0][r] = data; rslot[0][r] = s0;
        rdata[1][r] = data; rslot[1][r] = s1;
    endtask

    // Drive a request pattern for exactly one capture edge, then let it drain.
    task automatic pulse(input logic [1:0] pat);
        @(negedge clk);
        for (int d = 0; d < 2; d++) req[d] = pat;
        @(negedge clk);
        clear_req();
        repeat (8) @(negedge clk);
    endtask

    // Hold a pattern long enough for three back-to-back captures per instance.
    task automatic hold_req(input logic [1:0] pat);
        for (int k = 0; k < 2 * 7 + 3 + 8; k++) begin
            for (int d = 0; d < 2; d++) req[d] = (k < 2 * tt(d) + 3) ? pat : 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic random_phase(input int ncyc);
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) dst[d][r] = 0;
        repeat (ncyc) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 2; r++) begin
                    case (dst[d][r])
                        0: if ($urandom_range(99) < 35) begin
                            rdata[d][r] = 4'($urandom);
                            rslot[d][r] = 3'($urandom_range(pns[d] - 1));
                            req[d][r]   = 1'b1;
                            dst[d][r]   = 1;
                        end
                        1: if (active[d] && m_grant[d] == r && m_cap[d] == cyc) dst[d][r] = 2;
                        default: begin
                            if (cyc == m_cap[d] + tt(d) - 1) begin
                                // ack cycle: either re-request straight away or go quiet
                                if ($urandom_range(99) < 50) begin
                                    rdata[d][r] = 4'($urandom);
                                    rslot[d][r] = 3'($urandom_range(pns[d] - 1));
                                    req[d][r]   = 1'b1;
                                    dst[d][r]   = 1;
                                end else begin
                                    req[d][r] = 1'b0;
                                    dst[d][r] = 0;
                                end
                            end else begin
                                // captured inputs must be ignored from here on
                                if ($urandom_range(99) < 30) begin
                                    rdata[d][r] = 4'($urandom);
                                    rslot[d][r] = 3'($urandom_range(pns[d] - 1));
                                end
                                if ($urandom_range(99) < 15) req[d][r] = 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
        clear_req();
    endtask

    initial begin
        clear_req();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                rdata[d][r] = '0;
                rslot[d][r] = '0;
            end
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write: data 0xA to slot 2 (slot 7 on the 8-slot instance)
        set_both(0, 4'hA, 3'd2, 3'd7);
        pulse(2'b01);

        // requester data changes after capture must not reach latch_d
        set_both(0, 4'h3, 3'd1, 3'd5);
        @(negedge clk);
        for (int d = 0; d < 2; d++) req[d] = 2'b01;
        @(negedge clk);
        clear_req();
        set_both(0, 4'hC, 3'd0, 3'd0);
        @(negedge clk);
        set_both(0, 4'h6, 3'd3, 3'd2);
        repeat (8) @(negedge clk);

        // contention: both held across three transactions
        set_both(0, 4'h5, 3'd0, 3'd0);
        set_both(1, 4'h9, 3'd3, 3'd6);
        hold_req(2'b11);

        // single requester held: back-to-back with one idle cycle between
        set_both(0, 4'h1, 3'd1, 3'd4);
        hold_req(2'b01);

        // asynchronous reset in the middle of the open window
        set_both(0, 4'h6, 3'd1, 3'd1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) req[d] = 2'b01;
        @(negedge clk);
        clear_req();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_latch_g",  d, 32'(lg_a[d]),   32'd0);
            check("rst_busy",     d, 32'(busy_a[d]), 32'd0);
            check("rst_ack",      d, 32'(ack_a[d]),  32'd0);
            check("rst_latch_d",  d, 32'(ld_a[d]),   32'd0);
            check("rst_grant_id", d, 32'(gid_a[d]),  32'd0);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // pointer must favour requester 0 again, then a lone requester 1
        set_both(0, 4'h7, 3'd3, 3'd3);
        set_both(1, 4'h8, 3'd1, 3'd6);
        pulse(2'b11);
        set_both(1, 4'hB, 3'd2, 3'd7);
        pulse(2'b10);

        random_phase(400);
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
